// File: rtl/counter_arbiter.sv
// Round-robin scheduler sharing one interval counter among N_REQ requesters.
// Grants one requester at a time, counts 0..len, then pulses that requester's done.
module counter_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_len,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       count,
  output logic [N_REQ-1:0]       done
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [IW-1:0]    last_grant, last_grant_d;
  logic [IW-1:0]    win_q, win_q_d;
  logic [IW-1:0]    pick, rr_idx;
  logic             found;
  logic [WIDTH-1:0] len_q, len_d, count_d;
  logic [N_REQ-1:0] gnt_d, done_d;
  logic             busy_d;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      rr_idx = IW'((32'(last_grant) + k) % N_REQ);
      if (!found && req[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (found) state_d = RUN;
      RUN: begin
        if (!req[win_q])         state_d = IDLE;
        else if (count == len_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d        = gnt;
    done_d       = '0;
    busy_d       = busy;
    count_d      = count;
    len_d        = len_q;
    last_grant_d = last_grant;
    win_q_d      = win_q;
    case (state)
      IDLE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (found) begin
          gnt_d[pick]  = 1'b1;
          busy_d       = 1'b1;
          len_d        = req_len[pick*WIDTH +: WIDTH];
          last_grant_d = pick;
          win_q_d      = pick;
        end
      end
      RUN: begin
        // Cancel wins over expiry; count holds through the done cycle.
        if (!req[win_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (count == len_q) begin
          done_d = gnt;
          gnt_d  = '0;
          busy_d = 1'b0;
        end else begin
          count_d = count + 1'b1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      count      <= '0;
      len_q      <= '0;
      last_grant <= IW'(N_REQ - 1);
      win_q      <= '0;
    end else begin
      gnt        <= gnt_d;
      done       <= done_d;
      busy       <= busy_d;
      count      <= count_d;
      len_q      <= len_d;
      last_grant <= last_grant_d;
      win_q      <= win_q_d;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: reset, single request, round-robin,
// length boundaries, cancel and mid-run reset, with hand-computed expectations.
module tb_counter_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_len;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  count;
  logic [3:0]  done;

  int checks;
  int errors;

  counter_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .busy    (busy),
    .count   (count),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {gnt, done, busy, count} against the expected tuple.
  task automatic chk(input string tag, input logic [3:0] g, input logic [3:0] d,
                     input logic b, input logic [7:0] c);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {gnt, done, busy, count};
    exp = {g, d, b, c};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed gnt=%b done=%b busy=%b count=%0d expected gnt=%b done=%b busy=%b count=%0d",
             tag, gnt, done, busy, count, g, d, b, c);
    end
  endtask

  initial begin
    logic [3:0] oh;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = 4'b1111;
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 4'b0000, 4'b0000, 1'b0, 8'd0);
    end

    // Round-robin with all lengths 1, starting from requester 0.
    rst_n = 1'b1;
    for (int r = 0; r < 5; r++) begin
      oh = 4'b0001 << (r % 4);
      tick(); chk("rr_grant",  oh,      4'b0000, 1'b1, 8'd0);
      tick(); chk("rr_count",  oh,      4'b0000, 1'b1, 8'd1);
      tick(); chk("rr_done",   4'b0000, oh,      1'b0, 8'd1);
      tick(); chk("rr_gap",    4'b0000, 4'b0000, 1'b0, 8'd0);
    end
    req = 4'b0000;
    tick(); chk("idle_noreq", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Single request, len 5; length change and other requests mid-run ignored.
    req = 4'b0100;
    req_len[16 +: 8] = 8'd5;
    tick(); chk("single_grant", 4'b0100, 4'b0000, 1'b1, 8'd0);
    req_len[16 +: 8] = 8'd2;
    req = 4'b0101;
    for (int i = 1; i <= 5; i++) begin
      tick(); chk("single_count", 4'b0100, 4'b0000, 1'b1, 8'(i));
    end
    tick(); chk("single_done", 4'b0000, 4'b0100, 1'b0, 8'd5);
    req = 4'b0000;
    tick(); chk("single_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // len 0: one grant cycle then done.
    req = 4'b0001;
    req_len[0 +: 8] = 8'd0;
    tick(); chk("len0_grant", 4'b0001, 4'b0000, 1'b1, 8'd0);
    tick(); chk("len0_done",  4'b0000, 4'b0001, 1'b0, 8'd0);
    req = 4'b0000;
    tick(); chk("len0_idle",  4'b0000, 4'b0000, 1'b0, 8'd0);

    // len 255: 256 grant cycles, count tops out at FF without wrap.
    req = 4'b1000;
    req_len[24 +: 8] = 8'hFF;
    tick(); chk("len255_grant", 4'b1000, 4'b0000, 1'b1, 8'd0);
    for (int i = 1; i <= 255; i++) begin
      tick(); chk("len255_count", 4'b1000, 4'b0000, 1'b1, 8'(i));
    end
    tick(); chk("len255_done", 4'b0000, 4'b1000, 1'b0, 8'hFF);
    req = 4'b0000;
    tick(); chk("len255_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Cancel requester 1 at count 3; requester 3 pending gets the next grant.
    req = 4'b1010;
    req_len[8 +: 8]  = 8'd10;
    req_len[24 +: 8] = 8'd1;
    for (int i = 0; i <= 3; i++) begin
      tick(); chk("cancel_run", 4'b0010, 4'b0000, 1'b1, 8'(i));
    end
    req = 4'b1000;
    tick(); chk("cancel_clear", 4'b0000, 4'b0000, 1'b0, 8'd0);
    tick(); chk("cancel_next",  4'b1000, 4'b0000, 1'b1, 8'd0);
    tick(); chk("cancel_next1", 4'b1000, 4'b0000, 1'b1, 8'd1);
    tick(); chk("cancel_ndone", 4'b0000, 4'b1000, 1'b0, 8'd1);
    req = 4'b0000;
    tick(); chk("cancel_idle",  4'b0000, 4'b0000, 1'b0, 8'd0);

    // Cancel in the count==len cycle suppresses done.
    req = 4'b0010;
    req_len[8 +: 8] = 8'd2;
    for (int i = 0; i <= 2; i++) begin
      tick(); chk("cancel_end_run", 4'b0010, 4'b0000, 1'b1, 8'(i));
    end
    req = 4'b0000;
    tick(); chk("cancel_end_nodone", 4'b0000, 4'b0000, 1'b0, 8'd0);
    tick(); chk("cancel_end_idle",   4'b0000, 4'b0000, 1'b0, 8'd0);

    // Mid-run reset at count 4, then arbitration restarts at requester 0.
    req = 4'b0100;
    req_len[16 +: 8] = 8'd9;
    for (int i = 0; i <= 4; i++) begin
      tick(); chk("midrst_run", 4'b0100, 4'b0000, 1'b1, 8'(i));
    end
    rst_n = 1'b0;
    tick(); chk("midrst_clear", 4'b0000, 4'b0000, 1'b0, 8'd0);
    rst_n = 1'b1;
    req = 4'b1111;
    tick(); chk("midrst_first", 4'b0001, 4'b0000, 1'b1, 8'd0);
    rst_n = 1'b0;
    tick(); chk("final_reset",  4'b0000, 4'b0000, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares a single 8-bit interval counter among several requesters. Each requester asks for a timed interval of programmable length. The block grants the counter to one requester at a time, runs the count, and pulses a per-requester done when the interval expires. It sits between the control FSMs that need delays and the shared counter datapath, replacing per-client counter instances.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- WIDTH, default 8: counter and interval-length width.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: synchronous active-low reset, sampled on rising clk.
- req  in  N_REQ: level request per requester; must be held until done or until the requester cancels.
- req_len  in  N_REQ*WIDTH: interval length per requester, slice i = [i*WIDTH +: WIDTH]; sampled only at grant.
- gnt  out  N_REQ: one-hot grant, registered; all-zero when idle.
- busy  out  1: high while an interval is running (RUN state).
- count  out  WIDTH: current counter value, registered.
- done  out  N_REQ: one-cycle pulse to the requester whose interval completed.

## Operation
- Reset (rst_n=0 at an edge), all outputs and state:
  - state=IDLE; gnt=0, done=0, busy=0, count=0.
  - last_grant pointer = N_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req is nonzero, select the winner by round-robin: first asserted index searching last_grant+1, last_grant+2, … modulo N_REQ.
  - Next edge: state=RUN, gnt=onehot(winner), busy=1, count=0, len_q=req_len slice of winner, last_grant=winner.
  - If req is zero, remain in IDLE with all outputs 0.
- RUN:
  - Cancel: if req[winner]=0, the next edge goes to IDLE with gnt=0, busy=0, count=0 and no done pulse.
  - Expiry: else if count==len_q, the next edge goes to DONE with done[winner]=1, gnt=0, busy=0, and count holding its value.
  - Otherwise count increments by 1.
  - Cancel has priority over expiry when both occur in the same cycle.
- DONE:
  - Lasts exactly 1 cycle with done one-hot high.
  - Next edge: IDLE, done=0, count=0.
  - Requests are not arbitrated in DONE.
- Counting rules:
  - count never exceeds len_q, so there is no wrap-around.
  - len_q=0 is legal: gnt is high for 1 cycle, then done.
  - len_q=2^WIDTH-1 gives 2^WIDTH grant cycles.
- Changes to req_len after grant are ignored.
- Changes on non-winning req bits during RUN or DONE do not affect the current interval.
- gnt, done and busy are mutually consistent at all times:
  - busy equals |gnt.
  - done is nonzero only when gnt=0.
- Reset asserted in any state, including mid-RUN, takes effect at that edge: return to reset values, no done pulse.

## Timing
- Request to grant: req seen in IDLE at edge t gives gnt from edge t+1.
- Grant duration: len_q+1 cycles; count shows 0..len_q during that period.
- Done pulse: starts on the edge after count==len_q, lasts 1 cycle.
- Back-to-back service: done at cycle d, IDLE at d+1, next gnt at d+2. Minimum per-interval occupancy is len_q+3 cycles.
- Cancel: the edge after req[winner] drops, gnt=0; a new grant is possible one cycle later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 → gnt=0, done=0, busy=0, count=0 throughout. First grant after release goes to requester 0.
- Single request: req=4'b0100 with len[2]=5 → gnt=4'b0100 for 6 cycles while count steps 0..5; then done=4'b0100 for 1 cycle; then idle.
- Round-robin fairness: req=4'b1111 held, all lengths=1 → grant order 0,1,2,3,0,…, with each done pulse followed by a 1-cycle IDLE gap before the next gnt.
- Boundaries:
  - len=0 → 1-cycle gnt, then done.
  - len=255 → 256 grant cycles with count reaching 8'hFF and no wrap.
- Cancel:
  - Drop req[1] when count=3 → gnt clears next edge, done stays 0, and the next pending requester is granted 2 cycles after the drop.
  - Drop req[1] exactly in the count==len cycle → no done pulse.
- Mid-run reset: assert rst_n=0 when count=4 → next edge gives all outputs 0 and no done. After release, arbitration restarts from requester 0.
